// File: rtl/window_generator_if.sv
// Pixel-stream in / 3x3 window out bundle between the upstream source, window_generator and the MAC.
// win[r][c] is 9-bit signed with the sign bit always 0; r0 = oldest line, c2 = newest column.
interface window_generator_if;
    logic                 stall;
    logic                 sof;
    logic [7:0]           pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [2:0][2:0][8:0] win;
    logic                 win_valid;
    logic                 frame_done;

    modport master (
        output stall, sof, pix_in, pix_valid,
        input  pix_ready, win, win_valid, frame_done
    );
    modport slave (
        input  stall, sof, pix_in, pix_valid,
        output pix_ready, win, win_valid, frame_done
    );
endinterface

// File: rtl/window_generator.sv
// 3x3 sliding-window generator over a raster pixel stream, built from two line buffers.
// Emits only interior windows; the whole block freezes while the downstream MAC stalls.
module window_generator #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              reset,
    window_generator_if.slave bus
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [7:0]           lba_q [IMG_WIDTH];
    logic [7:0]           lbb_q [IMG_WIDTH];
    logic [2:0][2:0][8:0] win_q, win_d;
    logic                 wv_q, wv_d;
    logic                 fd_q, fd_d;
    logic [CW-1:0]        col_q, col_d, col_eff;
    logic [RW-1:0]        row_q, row_d, row_eff;
    logic                 accept, last_col, last_row;

    assign bus.pix_ready = !bus.stall;
    assign accept        = bus.pix_valid && !bus.stall;
    // sof re-anchors the counters at the pixel that carries it
    assign col_eff       = bus.sof ? '0 : col_q;
    assign row_eff       = bus.sof ? '0 : row_q;
    assign last_col      = (col_eff == CW'(IMG_WIDTH - 1));
    assign last_row      = (row_eff == RW'(IMG_HEIGHT - 1));

    always_comb begin
        win_d = win_q;
        wv_d  = wv_q;
        fd_d  = fd_q;
        col_d = col_q;
        row_d = row_q;
        if (!bus.stall) begin
            wv_d = 1'b0;
            fd_d = 1'b0;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                end
                win_d[0][2] = {1'b0, lba_q[col_eff]};
                win_d[1][2] = {1'b0, lbb_q[col_eff]};
                win_d[2][2] = {1'b0, bus.pix_in};
                wv_d = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
                fd_d = last_row && last_col;
                if (last_col) begin
                    col_d = '0;
                    row_d = last_row ? '0 : row_eff + 1'b1;
                end else begin
                    col_d = col_eff + 1'b1;
                    row_d = row_eff;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
            wv_q  <= 1'b0;
            fd_q  <= 1'b0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            win_q <= win_d;
            wv_q  <= wv_d;
            fd_q  <= fd_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line buffers carry no reset: rows 0/1 of every frame refill them before any window is emitted
    always_ff @(posedge clk) begin
        if (accept) begin
            lba_q[col_eff] <= lbb_q[col_eff];
            lbb_q[col_eff] <= bus.pix_in;
        end
    end

    assign bus.win        = win_q;
    assign bus.win_valid  = wv_q;
    assign bus.frame_done = fd_q;
endmodule
